cache_line_fill: RTL and testbench

Line-refill engine for the direct-mapped cache. On a miss it accepts the miss address, fetches the whole line from memory one data word at a time over a pipelined request/response interface, and writes each word into the cache data array. It then commits the tag and valid bit for that index. It sits between the cache lookup/hit logic (upstream, the miss source) and the memory port (downstream).

---
 rtl/cache_line_fill_pkg.sv | 15 +
 rtl/cache_line_fill.sv | 124 ++++++++++++
 tb/tb_cache_line_fill.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_line_fill_pkg.sv
// cache_line_fill_pkg: cache geometry, derived field widths and fill FSM state type
package cache_line_fill_pkg;
    localparam int ADDR_WIDTH      = 32;
    localparam int DATA_WIDTH      = 8;
    localparam int SIZE            = 1024;
    localparam int LINE_SIZE       = 256;
    localparam int NUM_LINES       = SIZE / LINE_SIZE;
    localparam int MAX_OUTSTANDING = 4;
    localparam int OFFSET_BITS     = $clog2(LINE_SIZE);
    localparam int IDX_BITS        = $clog2(NUM_LINES);
    localparam int TAG_BITS        = ADDR_WIDTH - IDX_BITS - OFFSET_BITS;
    localparam int CNT_BITS        = OFFSET_BITS + 1;
    localparam int OUT_BITS        = $clog2(MAX_OUTSTANDING) + 1;
    typedef enum logic [1:0] {IDLE, FILL, COMMIT} fill_state_t;
endpackage

// File: rtl/cache_line_fill.sv
// cache_line_fill: refills one cache line word-by-word from a pipelined memory port, then commits tag/valid
//   miss_valid/miss_ready/miss_addr       : miss request from lookup (offset bits ignored)
//   mem_req_valid/ready/addr              : word read requests, at most MAX_OUTSTANDING in flight
//   mem_rsp_valid/ready/data              : in-order read responses
//   arr_we/idx/offset/wdata               : data-array word write per response
//   tag_we/idx/wdata/wvalid               : invalidate at accept, commit tag+valid at end of fill
//   busy, fill_done                       : engine not idle; one-cycle commit pulse
module cache_line_fill
    import cache_line_fill_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   miss_valid,
    output logic                   miss_ready,
    input  logic [ADDR_WIDTH-1:0]  miss_addr,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_rsp_valid,
    output logic                   mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0]  mem_rsp_data,
    output logic                   arr_we,
    output logic [IDX_BITS-1:0]    arr_idx,
    output logic [OFFSET_BITS-1:0] arr_offset,
    output logic [DATA_WIDTH-1:0]  arr_wdata,
    output logic                   tag_we,
    output logic [IDX_BITS-1:0]    tag_idx,
    output logic [TAG_BITS-1:0]    tag_wdata,
    output logic                   tag_wvalid,
    output logic                   busy,
    output logic                   fill_done
);
    localparam logic [CNT_BITS-1:0] FULL    = CNT_BITS'(LINE_SIZE);
    localparam logic [CNT_BITS-1:0] LAST    = CNT_BITS'(LINE_SIZE - 1);
    localparam logic [OUT_BITS-1:0] MAX_OUT = OUT_BITS'(MAX_OUTSTANDING);

    fill_state_t           state, state_n;
    logic [TAG_BITS-1:0]   tag;
    logic [IDX_BITS-1:0]   idx;
    logic [CNT_BITS-1:0]   req_cnt, rsp_cnt;
    logic [OUT_BITS-1:0]   outstanding;
    logic                  accept, req_hs, rsp_hs;
    logic                  unused_offset;

    assign unused_offset = ^miss_addr[OFFSET_BITS-1:0];
    // counters never wrap within a fill, so the truncated difference is the in-flight count
    assign outstanding = OUT_BITS'(req_cnt - rsp_cnt);
    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag     <= '0;
            idx     <= '0;
            req_cnt <= '0;
            rsp_cnt <= '0;
        end else if (accept) begin
            tag     <= miss_addr[ADDR_WIDTH-1 -: TAG_BITS];
            idx     <= miss_addr[OFFSET_BITS +: IDX_BITS];
            req_cnt <= '0;
            rsp_cnt <= '0;
        end else begin
            req_cnt <= req_cnt + CNT_BITS'(req_hs);
            rsp_cnt <= rsp_cnt + CNT_BITS'(rsp_hs);
        end
    end

    always_comb begin
        state_n       = state;
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_rsp_ready = 1'b0;
        arr_we        = 1'b0;
        arr_idx       = '0;
        arr_offset    = '0;
        arr_wdata     = '0;
        tag_we        = 1'b0;
        tag_idx       = '0;
        tag_wdata     = '0;
        tag_wvalid    = 1'b0;
        fill_done     = 1'b0;
        accept        = 1'b0;
        req_hs        = 1'b0;
        rsp_hs        = 1'b0;
        case (state)
            IDLE: begin
                miss_ready = 1'b1;
                accept     = miss_valid;
                // invalidate the target line for the duration of the fill
                tag_we     = miss_valid;
                tag_idx    = miss_valid ? miss_addr[OFFSET_BITS +: IDX_BITS] : '0;
                state_n    = miss_valid ? FILL : IDLE;
            end
            FILL: begin
                mem_req_valid = req_cnt < FULL && outstanding < MAX_OUT;
                mem_req_addr  = {tag, idx, req_cnt[OFFSET_BITS-1:0]};
                mem_rsp_ready = 1'b1;
                req_hs        = mem_req_valid && mem_req_ready;
                rsp_hs        = mem_rsp_valid;
                arr_we        = rsp_hs;
                arr_idx       = rsp_hs ? idx : '0;
                arr_offset    = rsp_hs ? rsp_cnt[OFFSET_BITS-1:0] : '0;
                arr_wdata     = rsp_hs ? mem_rsp_data : '0;
                state_n       = (rsp_hs && rsp_cnt == LAST) ? COMMIT : FILL;
            end
            COMMIT: begin
                tag_we     = 1'b1;
                tag_idx    = idx;
                tag_wdata  = tag;
                tag_wvalid = 1'b1;
                fill_done  = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_line_fill.sv
// tb_cache_line_fill: scoreboard bench with a latency/ready-configurable memory model
module tb_cache_line_fill;
    import cache_line_fill_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   miss_valid = 1'b0;
    logic                   miss_ready;
    logic [ADDR_WIDTH-1:0]  miss_addr = '0;
    logic                   mem_req_valid;
    logic                   mem_req_ready = 1'b0;
    logic [ADDR_WIDTH-1:0]  mem_req_addr;
    logic                   mem_rsp_valid = 1'b0;
    logic                   mem_rsp_ready;
    logic [DATA_WIDTH-1:0]  mem_rsp_data = '0;
    logic                   arr_we;
    logic [IDX_BITS-1:0]    arr_idx;
    logic [OFFSET_BITS-1:0] arr_offset;
    logic [DATA_WIDTH-1:0]  arr_wdata;
    logic                   tag_we;
    logic [IDX_BITS-1:0]    tag_idx;
    logic [TAG_BITS-1:0]    tag_wdata;
    logic                   tag_wvalid;
    logic                   busy;
    logic                   fill_done;

    always #5 clk = ~clk;

    cache_line_fill dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .arr_we(arr_we), .arr_idx(arr_idx), .arr_offset(arr_offset), .arr_wdata(arr_wdata),
        .tag_we(tag_we), .tag_idx(tag_idx), .tag_wdata(tag_wdata), .tag_wvalid(tag_wvalid),
        .busy(busy), .fill_done(fill_done)
    );

    typedef struct { logic [ADDR_WIDTH-1:0] addr; int due; } rsp_t;
    typedef struct { logic [IDX_BITS-1:0] idx; logic [OFFSET_BITS-1:0] off; logic [DATA_WIDTH-1:0] data; } wr_t;

    rsp_t                  mem_q[$];
    wr_t                   wr_q[$];
    logic [ADDR_WIDTH-1:0] req_q[$];
    logic [ADDR_WIDTH-1:0] miss_q[$];
    int                    n_chk = 0, n_fail = 0, cyc = 0, lat = 1, bstate = 0;
    int                    acc_cyc = 0, done_cyc = 0, issued = 0, words = 0;
    bit                    rnd_rdy = 0, spur = 0, timing_chk = 0, miss_waiting = 0, prev_stall = 0;
    logic [ADDR_WIDTH-1:0] prev_addr = '0;
    logic [7:0]            salt = 8'h00;
    logic [TAG_BITS-1:0]   exp_tag = '0;
    logic [IDX_BITS-1:0]   exp_idx = '0;

    function automatic logic [DATA_WIDTH-1:0] mem_data(logic [ADDR_WIDTH-1:0] a);
        return DATA_WIDTH'((a[7:0] * 8'd13) ^ a[15:8] ^ salt);
    endfunction

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic observe();
        bit                    acc;
        int                    nxt;
        logic [ADDR_WIDTH-1:0] base, a;
        wr_t                   w;
        acc = miss_valid && miss_ready;
        nxt = bstate;
        check("miss_ready", miss_ready, bstate == 0);
        check("busy", busy, bstate != 0);
        check("req_valid", mem_req_valid, bstate == 1 && issued < LINE_SIZE && mem_q.size() < MAX_OUTSTANDING);
        check("rsp_ready", mem_rsp_ready, bstate == 1);
        check("arr_we", arr_we, bstate == 1 && mem_rsp_valid);
        check("fill_done", fill_done, bstate == 2);
        check("tag_we", tag_we, acc || bstate == 2);
        check("tag_wvalid", tag_wvalid, bstate == 2);
        if (prev_stall) begin
            check("hold_valid", mem_req_valid, 1);
            check("hold_addr", mem_req_addr, prev_addr);
        end
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_addr  = mem_req_addr;
        if (acc) begin
            base    = miss_q[0] & ~ADDR_WIDTH'(LINE_SIZE - 1);
            exp_tag = TAG_BITS'(base >> (OFFSET_BITS + IDX_BITS));
            exp_idx = IDX_BITS'((base >> OFFSET_BITS) % NUM_LINES);
            check("inv_idx", tag_idx, exp_idx);
            if (miss_waiting) check("b2b_accept_cycle", cyc, done_cyc + 1);
            for (int i = 0; i < LINE_SIZE; i++) begin
                a = base + ADDR_WIDTH'(i);
                req_q.push_back(a);
                wr_q.push_back('{idx: exp_idx, off: OFFSET_BITS'(i), data: mem_data(a)});
            end
            void'(miss_q.pop_front());
            acc_cyc = cyc; issued = 0; words = 0; miss_waiting = 0;
            nxt = 1;
        end
        if (mem_req_valid && mem_req_ready) begin
            check("req_pending", req_q.size() > 0, 1);
            if (req_q.size() > 0) check("req_addr", mem_req_addr, req_q.pop_front());
            mem_q.push_back('{addr: mem_req_addr, due: cyc + lat});
            issued++;
        end
        if (mem_rsp_valid && mem_rsp_ready && mem_q.size() > 0) void'(mem_q.pop_front());
        if (arr_we) begin
            check("wr_pending", wr_q.size() > 0, 1);
            if (wr_q.size() > 0) begin
                w = wr_q.pop_front();
                check("arr_idx", arr_idx, w.idx);
                check("arr_offset", arr_offset, w.off);
                check("arr_wdata", arr_wdata, w.data);
                words++;
                if (wr_q.size() == 0 && bstate == 1) nxt = 2;
            end
        end
        if (fill_done) begin
            check("commit_tag", tag_wdata, exp_tag);
            check("commit_idx", tag_idx, exp_idx);
            if (timing_chk) check("done_cycle", cyc - acc_cyc, LINE_SIZE + 2);
            done_cyc = cyc;
            miss_waiting = miss_valid;
        end
        if (bstate == 2) nxt = 0;
        bstate = nxt;
    endtask

    task automatic cycle(bit do_rst = 0);
        @(negedge clk);
        rst_n         = !do_rst;
        mem_req_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        miss_valid    = !do_rst && miss_q.size() > 0;
        miss_addr     = miss_q.size() > 0 ? miss_q[0] : '0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        if (!do_rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_data(mem_q[0].addr);
        end else if (!do_rst && spur && bstate == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = DATA_WIDTH'($urandom);
        end
        #1;
        if (do_rst) begin
            check("rst_ready_busy", {miss_ready, busy}, 2'b10);
            check("rst_outputs", {mem_req_valid, mem_rsp_ready, arr_we, arr_idx, arr_offset, arr_wdata,
                                  tag_we, tag_idx, tag_wdata, tag_wvalid, fill_done, mem_req_addr}, '0);
            bstate = 0; prev_stall = 0; miss_waiting = 0;
            mem_q.delete(); req_q.delete(); wr_q.delete(); miss_q.delete();
        end else
            observe();
        cyc++;
    endtask

    task automatic run_idle(int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while ((bstate != 0 || miss_q.size() > 0 || mem_q.size() > 0) && n < budget);
        check("drain_in_budget", n < budget, 1);
        cycle();
    endtask

    initial begin
        cycle(1);
        cycle(1);
        // basic fill, ready memory, 1-cycle latency
        timing_chk = 1; salt = 8'h3C;
        miss_q.push_back(32'h0000_1234);
        run_idle(2000);
        timing_chk = 0;
        // long latency limited by outstanding cap
        lat = 10; salt = 8'h71;
        miss_q.push_back(32'h0000_0A80);
        run_idle(6000);
        // random request backpressure
        lat = 3; rnd_rdy = 1; salt = 8'hC5;
        miss_q.push_back(32'hDEAD_BE42);
        run_idle(6000);
        rnd_rdy = 0;
        // spurious responses while idle
        spur = 1;
        repeat (8) cycle();
        spur = 0;
        // reset in the middle of a fill, then restart
        lat = 2; salt = 8'h18;
        miss_q.push_back(32'h0000_0100);
        for (int n = 0; n < 2000 && !(bstate == 1 && words >= 100); n++) cycle();
        check("reached_100_words", words, 100);
        cycle(1);
        cycle();
        miss_q.push_back(32'h0000_0300);
        run_idle(3000);
        // back-to-back misses with miss_valid held through the fill
        lat = 1; spur = 1; salt = 8'h96;
        miss_q.push_back(32'h0001_0000);
        miss_q.push_back(32'h0001_0155);
        run_idle(3000);
        spur = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
